// File: rtl/mips_data_mem_responder_pkg.sv
// Shared types and widths for the data-memory responder.
package mips_data_mem_responder_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BYTE_ADDR_W    = 32;
    localparam int unsigned LAT_CNT_W      = 3;  // holds READ_LATENCY-1 for latencies 1..7
    localparam int unsigned WBUF_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_WAIT = 2'd1,
        ST_READ_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// Data-port bundle between the core (master) and the responder (slave).
interface mips_data_mem_responder_if;
    import mips_data_mem_responder_pkg::*;

    logic                   mem_ren;
    logic                   mem_wen;
    logic [BYTE_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]      mem_dout;
    logic [DATA_W-1:0]      mem_din;
    logic                   mem_stall;
    logic                   wbuf_empty;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        input  mem_din, mem_stall, wbuf_empty
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        output mem_din, mem_stall, wbuf_empty
    );

endinterface

// File: rtl/mips_data_mem_responder_data_ram.sv
// Single-port synchronous word RAM; read data appears READ_LATENCY cycles after the request.
module mips_data_mem_responder_data_ram #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_W-1:0] mem  [DEPTH];
    logic [DATA_W-1:0] pipe [READ_LATENCY];

    // Array write port.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    // Array read into the first stage, then a free-running delay line.
    always_ff @(posedge clk) begin
        if (en && !we) begin
            pipe[0] <= mem[addr];
        end
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[READ_LATENCY-1];

endmodule

// File: rtl/mips_data_mem_responder.sv
// Data-memory responder: posted write buffer with forwarding in front of a latency-configurable RAM.
module mips_data_mem_responder
    import mips_data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WBUF_DEPTH   = WBUF_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_data_mem_responder_if.slave  bus
);

    localparam int unsigned PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LATENCY - 1);

    state_t                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0]  buf_addr_q [WBUF_DEPTH];
    logic [DATA_W-1:0]      buf_data_q [WBUF_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]       count_q;

    logic [ADDR_WIDTH-1:0]  req_index;
    logic                   wr_req, rd_req;
    logic                   buf_full, buf_any;
    logic                   hit;
    logic [DATA_W-1:0]      hit_data;
    logic [PTR_W-1:0]       fwd_slot;

    logic                   miss, drain, push;
    logic                   stall_c;
    logic [DATA_W-1:0]      din_c;

    logic                   ram_en, ram_we;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [DATA_W-1:0]      ram_wdata, ram_dout;

    logic                   unused_addr_bits;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_index        = bus.mem_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{bus.mem_addr[BYTE_ADDR_W-1:ADDR_WIDTH+2], bus.mem_addr[1:0]};

    // A simultaneous read+write is handled purely as a write.
    assign wr_req   = bus.mem_wen;
    assign rd_req   = bus.mem_ren & ~bus.mem_wen;
    assign buf_full = (count_q == CNT_W'(WBUF_DEPTH));
    assign buf_any  = (count_q != '0);

    // Forwarding compare, walked oldest to youngest so the youngest match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        fwd_slot = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            fwd_slot = PTR_W'((32'(rd_ptr_q) + i) % WBUF_DEPTH);
            if ((CNT_W'(i) < count_q) && (buf_addr_q[fwd_slot] == req_index)) begin
                hit      = 1'b1;
                hit_data = buf_data_q[fwd_slot];
            end
        end
    end

    // FSM next state, drain/push arbitration and request-side outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        miss    = 1'b0;
        drain   = 1'b0;
        push    = 1'b0;
        stall_c = 1'b0;
        din_c   = '0;

        case (state_q)
            ST_IDLE: begin
                if (rd_req && !hit) begin
                    miss    = 1'b1;
                    stall_c = 1'b1;
                    cnt_d   = LAT_LOAD;
                    state_d = (READ_LATENCY == 1) ? ST_READ_DONE : ST_READ_WAIT;
                end else if (rd_req) begin
                    din_c = hit_data;
                end
                // A miss owns the RAM port this cycle.
                drain = buf_any && !miss;
            end
            ST_READ_WAIT: begin
                cnt_d = (cnt_q != '0) ? cnt_q - LAT_CNT_W'(1) : '0;
                if (cnt_q <= LAT_CNT_W'(1)) begin
                    state_d = ST_READ_DONE;
                end
                if (rd_req) begin
                    stall_c = 1'b1;
                end
            end
            ST_READ_DONE: begin
                state_d = ST_IDLE;
                drain   = buf_any;
                if (!bus.mem_wen) begin
                    din_c = ram_dout;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A full buffer still accepts a write on a cycle that frees a slot.
        push = wr_req && (!buf_full || drain);
        if (wr_req && !push) begin
            stall_c = 1'b1;
        end
    end

    assign ram_en    = miss | drain;
    assign ram_we    = drain;
    assign ram_addr  = miss ? req_index : buf_addr_q[rd_ptr_q];
    assign ram_wdata = buf_data_q[rd_ptr_q];

    // Outputs are forced quiet while reset is asserted, independent of the clock.
    assign bus.mem_stall  = rst & stall_c;
    assign bus.mem_din    = rst ? din_c : '0;
    assign bus.wbuf_empty = (count_q == '0);

    // FSM state, latency counter and buffer pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (drain) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(drain);
        end
    end

    // Buffer payload storage; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= req_index;
            buf_data_q[wr_ptr_q] <= bus.mem_dout;
        end
    end

    mips_data_mem_responder_data_ram #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_wdata),
        .dout (ram_dout)
    );

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Bench for the data-memory responder: vector table on a latency-2 instance, corner sequences on latency-4.
module tb_mips_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mips_data_mem_responder_if b2 ();
    mips_data_mem_responder_if b4 ();

    mips_data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(2), .WBUF_DEPTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    mips_data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(4), .WBUF_DEPTH(2)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] dout;
        logic        stall;
        logic [31:0] din;
        logic        empty;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic ren, input logic wen, input logic [31:0] addr,
                               input logic [31:0] dout, input logic stall,
                               input logic [31:0] din, input logic empty);
        vec_t r;
        r.ren = ren; r.wen = wen; r.addr = addr; r.dout = dout;
        r.stall = stall; r.din = din; r.empty = empty;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv2(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] dout);
        b2.mem_ren = ren; b2.mem_wen = wen; b2.mem_addr = addr; b2.mem_dout = dout;
    endtask

    task automatic drv4(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] dout);
        b4.mem_ren = ren; b4.mem_wen = wen; b4.mem_addr = addr; b4.mem_dout = dout;
    endtask

    task automatic wait_empty4(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (b4.wbuf_empty === 1'b1) ok = 1'b1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: wbuf_empty still 0 after 20 cycles, expected 1", name);
        end
    endtask

    // Full miss on the latency-4 instance: expects 4 stall cycles then the data.
    task automatic read4(input string name, input logic [31:0] addr, input logic [31:0] exp);
        int  cyc = 0;
        bit  done = 1'b0;
        logic [31:0] got = '0;
        @(negedge clk);
        drv4(1'b1, 1'b0, addr, 32'h0);
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (b4.mem_stall === 1'b0) begin
                done = 1'b1;
                got  = b4.mem_din;
            end else begin
                cyc++;
                @(negedge clk);
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s_timeout: mem_stall still 1 after 20 cycles, expected 0", name);
        end
        check({name, "_data"}, got, exp);
        check({name, "_stall_cycles"}, 32'(cyc), 32'd4);
        @(negedge clk);
        drv4(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        drv2(1'b0, 1'b0, 32'h0, 32'h0);
        drv4(1'b0, 1'b0, 32'h0, 32'h0);

        // Idle after reset.
        for (int i = 0; i < 5; i++) vq.push_back(v(0, 0, 32'h0, 32'h0, 0, 32'h0, 1));
        // Posted write then forwarded read.
        vq.push_back(v(0, 1, 32'h40, 32'hDEADBEEF, 0, 32'h0, 1));
        vq.push_back(v(1, 0, 32'h40, 32'h0, 0, 32'hDEADBEEF, 0));
        vq.push_back(v(0, 0, 32'h0, 32'h0, 0, 32'h0, 1));
        // Preload word 0x10 through the buffer, then a full miss.
        vq.push_back(v(0, 1, 32'h40, 32'h12345678, 0, 32'h0, 1));
        vq.push_back(v(0, 0, 32'h0, 32'h0, 0, 32'h0, 0));
        vq.push_back(v(1, 0, 32'h40, 32'h0, 1, 32'h0, 1));
        vq.push_back(v(1, 0, 32'h40, 32'h0, 1, 32'h0, 1));
        vq.push_back(v(1, 0, 32'h40, 32'h0, 0, 32'h12345678, 1));
        vq.push_back(v(0, 0, 32'h0, 32'h0, 0, 32'h0, 1));
        // Back-to-back writes to one word; latest value forwarded, then read from RAM.
        vq.push_back(v(0, 1, 32'h80, 32'h1, 0, 32'h0, 1));
        vq.push_back(v(0, 1, 32'h80, 32'h2, 0, 32'h0, 0));
        vq.push_back(v(1, 0, 32'h80, 32'h0, 0, 32'h2, 0));
        vq.push_back(v(1, 0, 32'h80, 32'h0, 1, 32'h0, 1));
        vq.push_back(v(1, 0, 32'h80, 32'h0, 1, 32'h0, 1));
        vq.push_back(v(1, 0, 32'h80, 32'h0, 0, 32'h2, 1));
        // Aliased address hits the buffer.
        vq.push_back(v(0, 1, 32'h1040, 32'hCAFEF00D, 0, 32'h0, 1));
        vq.push_back(v(1, 0, 32'h40, 32'h0, 0, 32'hCAFEF00D, 0));
        // Read+write together behaves as a write.
        vq.push_back(v(1, 1, 32'h44, 32'h5555AAAA, 0, 32'h0, 1));
        vq.push_back(v(1, 0, 32'h44, 32'h0, 0, 32'h5555AAAA, 0));
        // Miss whose request is dropped mid-wait still presents its data.
        vq.push_back(v(1, 0, 32'h44, 32'h0, 1, 32'h0, 1));
        vq.push_back(v(0, 0, 32'h44, 32'h0, 0, 32'h0, 1));
        vq.push_back(v(0, 0, 32'h0, 32'h0, 0, 32'h5555AAAA, 1));
        vq.push_back(v(0, 0, 32'h0, 32'h0, 0, 32'h0, 1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            drv2(vq[i].ren, vq[i].wen, vq[i].addr, vq[i].dout);
            #1;
            check($sformatf("vec%0d_stall", i), 32'(b2.mem_stall), 32'(vq[i].stall));
            check($sformatf("vec%0d_din", i), b2.mem_din, vq[i].din);
            check($sformatf("vec%0d_empty", i), 32'(b2.wbuf_empty), 32'(vq[i].empty));
        end
        @(negedge clk);
        drv2(1'b0, 1'b0, 32'h0, 32'h0);

        // Buffer fills during a latency-4 miss; third write waits for READ_DONE.
        @(negedge clk); drv4(1, 0, 32'h300, 32'h0);        #1; check("full_miss_stall", 32'(b4.mem_stall), 32'd1);
        @(negedge clk); drv4(0, 1, 32'h100, 32'h11111111); #1; check("full_w0_stall", 32'(b4.mem_stall), 32'd0);
        @(negedge clk); drv4(0, 1, 32'h104, 32'h22222222); #1; check("full_w1_stall", 32'(b4.mem_stall), 32'd0);
        @(negedge clk); drv4(0, 1, 32'h108, 32'h33333333); #1; check("full_w2_stall", 32'(b4.mem_stall), 32'd1);
        check("full_w2_empty", 32'(b4.wbuf_empty), 32'd0);
        @(negedge clk); #1; check("full_w2_accept", 32'(b4.mem_stall), 32'd0);
        @(negedge clk); drv4(0, 0, 32'h0, 32'h0);
        wait_empty4("full_drain");
        read4("full_rd100", 32'h100, 32'h11111111);
        read4("full_rd104", 32'h104, 32'h22222222);
        read4("full_rd108", 32'h108, 32'h33333333);

        // Two live entries for the same word: youngest wins, RAM ends with last value.
        @(negedge clk); drv4(1, 0, 32'h300, 32'h0); #1; check("yw_miss_stall", 32'(b4.mem_stall), 32'd1);
        @(negedge clk); drv4(0, 1, 32'h80, 32'h1);  #1; check("yw_w1_stall", 32'(b4.mem_stall), 32'd0);
        @(negedge clk); drv4(0, 1, 32'h80, 32'h2);  #1; check("yw_w2_stall", 32'(b4.mem_stall), 32'd0);
        @(negedge clk); drv4(0, 1, 32'h80, 32'h3);  #1; check("yw_w3_stall", 32'(b4.mem_stall), 32'd1);
        @(negedge clk); #1; check("yw_w3_accept", 32'(b4.mem_stall), 32'd0);
        @(negedge clk); drv4(1, 0, 32'h80, 32'h0);  #1;
        check("yw_hit_stall", 32'(b4.mem_stall), 32'd0);
        check("yw_hit_din", b4.mem_din, 32'h3);
        check("yw_hit_empty", 32'(b4.wbuf_empty), 32'd0);
        @(negedge clk); drv4(0, 0, 32'h0, 32'h0);
        wait_empty4("yw_drain");
        read4("yw_ram", 32'h80, 32'h3);

        // Asynchronous reset while a miss is waiting and a write is buffered.
        @(negedge clk); drv2(0, 1, 32'h200, 32'hAA); #1; check("rst_w_stall", 32'(b2.mem_stall), 32'd0);
        @(negedge clk); drv2(1, 0, 32'h300, 32'h0);  #1; check("rst_miss_stall", 32'(b2.mem_stall), 32'd1);
        @(negedge clk); #1;
        check("rst_wait_stall", 32'(b2.mem_stall), 32'd1);
        check("rst_wait_empty", 32'(b2.wbuf_empty), 32'd0);
        #1 rst = 1'b0;
        #1;
        check("rst_async_stall", 32'(b2.mem_stall), 32'd0);
        check("rst_async_din", b2.mem_din, 32'h0);
        check("rst_async_empty", 32'(b2.wbuf_empty), 32'd1);
        @(negedge clk); drv2(0, 0, 32'h0, 32'h0); rst = 1'b1; #1;
        check("rst_after_stall", 32'(b2.mem_stall), 32'd0);
        check("rst_after_empty", 32'(b2.wbuf_empty), 32'd1);
        check("rst_after_din", b2.mem_din, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mips_data_mem_responder.md
Name: mips_data_mem_responder

Overview:
- Responder side of the core's data-memory interface: accepts read/write requests, returns read data and stalls the requester while it works.
- Backing store is a single-port synchronous word RAM with configurable read latency.
- A 2-entry posted write buffer absorbs stores without stalling and drains to RAM on idle cycles.
- Reads that hit the buffer are forwarded the same cycle. Sits between mips_core's data port and on-chip data RAM.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words
READ_LATENCY, 2, RAM read latency in cycles (legal range 1..7)
WBUF_DEPTH, 2, posted write buffer entries (fixed 2 for this revision)

Ports:
clk  input  1  main clock, rising edge
rst  input  1  asynchronous, active-low reset
mem_ren  input  1  read request, held stable by requester while mem_stall=1
mem_wen  input  1  write request, held stable while mem_stall=1
mem_addr  input  32  byte address; bits [ADDR_WIDTH+1:2] index the RAM, others ignored
mem_dout  input  32  write data from requester
mem_din  output  32  read data returned to requester
mem_stall  output  1  request not yet completed; requester holds request
wbuf_empty  output  1  no posted writes pending (used for fence/flush)

Behaviour:
- Reset (rst=0, async): state=IDLE, buffer cleared (pending writes discarded), latency counter=0, mem_din=0, mem_stall=0, wbuf_empty=1.
- States:
  - IDLE: normal operation.
  - READ_WAIT: a RAM read is in flight.
  - READ_DONE: one cycle presenting the captured read data.
- A request completes in the cycle it is asserted with mem_stall=0.
- Write, IDLE, buffer not full: entry {word addr, data} pushed at the clock edge; mem_stall=0 (zero-latency accept).
- Write, buffer full: mem_stall=1 until a drain frees a slot. Push happens on the edge after the slot frees.
- A drain and a push may occur on the same edge. With one slot free, the push is accepted with no stall.
- Read, IDLE, address matches a buffer entry: mem_stall=0 and mem_din=buffered data combinationally in that cycle. The youngest matching entry wins. No RAM access.
- Read, IDLE, miss: mem_stall=1 and the RAM read is issued that cycle; go to READ_WAIT and load counter=READ_LATENCY-1.
  - READ_WAIT: counter decrements each cycle. At 0, RAM data is captured into the mem_din register; go to READ_DONE.
  - READ_DONE: mem_stall=0, mem_din=captured data; return to IDLE.
  - Total miss latency: READ_LATENCY+1 cycles including the request cycle.
- mem_ren and mem_wen both asserted: treated as a write only; mem_din=0.
- mem_din=0 in every cycle where no read completes.
- Drain:
  - RAM is single-port.
  - In any cycle where the RAM is not issuing or holding a read (IDLE with no miss, or READ_DONE), the oldest buffer entry is written to RAM; one entry per cycle.
  - Draining is paused during READ_WAIT.
  - A read miss issued in IDLE takes priority over the drain.
  - The buffer is FIFO-ordered. Duplicate addresses occupy separate entries, so write ordering to RAM is preserved.
- Buffer hit check compares only the RAM-index bits; aliased addresses hit.
- wbuf_empty=1 iff buffer count==0 (registered count, decoded combinationally).
- Request deasserted mid-READ_WAIT: the read still completes internally and returns to IDLE. mem_din is presented in READ_DONE regardless.
- Reset mid-read or mid-drain: the in-flight operation is abandoned; a RAM write already clocked is not undone.

Decomposition:
- Shared package/header (define.vh): state encodings (IDLE/READ_WAIT/READ_DONE) and the buffer-entry field widths.
- Sub-module data_ram:
  - single-port synchronous RAM with a READ_LATENCY-deep output pipeline;
  - ports clk, en, we, addr[ADDR_WIDTH-1:0], din, dout;
  - no reset on the array.
- The buffer, FIFO pointers, forwarding compare and FSM live in mips_data_mem_responder.

Test Plan:
- Reset then idle: after rst=0 pulse, mem_stall=0, mem_din=0, wbuf_empty=1 for 5 cycles with no requests.
- Posted write and forward: write 0x0000_0040 <- 0xDEAD_BEEF, then next cycle read 0x40. Required: mem_stall=0 both cycles; mem_din=0xDEADBEEF in the read cycle.
- Read miss latency (READ_LATENCY=2):
  - preload RAM word 0x10 with 0x1234_5678; read addr 0x40 with buffer empty;
  - required: mem_stall=1 for 2 cycles, then mem_din=0x12345678 with mem_stall=0 on the 3rd cycle.
- Buffer full: three back-to-back writes to 0x100/0x104/0x108 with a read miss in flight.
  - Required: third write stalls until READ_DONE drains an entry.
  - All three values are then read back correctly after wbuf_empty=1.
- Youngest-wins: write 0x80 <- 1 then 0x80 <- 2 on consecutive cycles, then immediately read 0x80. Required: mem_din=2 with no stall, and RAM holds 2 after drain.
- Async reset mid-read: assert rst=0 during READ_WAIT. Required: mem_stall=0, mem_din=0 and wbuf_empty=1 immediately, without waiting for a clock edge.
